// File: rtl/match_ctrl_if.sv
// Signal bundle between the match sequencer and the ball/paddle datapath.
// The slave side is the sequencer; the master side drives the game events.
interface match_ctrl_if #(
    parameter int SCORE_W = 4
);
    logic               start_btn;
    logic               frame_tick;
    logic               miss_a;
    logic               miss_b;
    logic               ball_run;
    logic               ball_load;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_a;
    logic [SCORE_W-1:0] score_b;
    logic               game_over;
    logic               winner;
    logic [2:0]         state;

    modport master (
        output start_btn, frame_tick, miss_a, miss_b,
        input  ball_run, ball_load, serve_dir, score_a, score_b,
               game_over, winner, state
    );

    modport slave (
        input  start_btn, frame_tick, miss_a, miss_b,
        output ball_run, ball_load, serve_dir, score_a, score_b,
               game_over, winner, state
    );
endinterface

// File: rtl/match_ctrl.sv
// Game-level sequencer for ping-pong: serve countdown, rally, point freeze,
// scoring and match end. Every output comes straight from a register.
module match_ctrl #(
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic        pixel_clk,
    input  logic        reset,
    match_ctrl_if.slave bus
);
    localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0]   SERVE_LD  = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]   POINT_LD  = CNT_W'(POINT_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    state_e             r_state,     w_state;
    logic [CNT_W-1:0]   r_cnt,       w_cnt;
    logic               r_ball_run,  w_ball_run;
    logic               r_ball_load, w_ball_load;
    logic               r_serve_dir, w_serve_dir;
    logic [SCORE_W-1:0] r_score_a,   w_score_a;
    logic [SCORE_W-1:0] r_score_b,   w_score_b;
    logic               r_game_over, w_game_over;
    logic               r_winner,    w_winner;
    logic               r_start_q;
    logic               r_armed;

    logic               w_start_edge;
    logic [SCORE_W-1:0] w_inc_a;
    logic [SCORE_W-1:0] w_inc_b;

    // r_armed blocks a start edge until the button has been seen low since
    // reset, so a button held through reset release cannot launch a match.
    assign w_start_edge = bus.start_btn & ~r_start_q & r_armed;
    assign w_inc_a      = r_score_a + SCORE_ONE;
    assign w_inc_b      = r_score_b + SCORE_ONE;

    always_comb begin
        // NOTE: every next-state value takes its held value first, so no path
        // through the case below can leave one unassigned and infer a latch.
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_ball_run  = r_ball_run;
        w_ball_load = 1'b0;
        w_serve_dir = r_serve_dir;
        w_score_a   = r_score_a;
        w_score_b   = r_score_b;
        w_game_over = r_game_over;
        w_winner    = r_winner;

        case (r_state)
            ST_IDLE, ST_GAME_OVER: begin
                if (w_start_edge) begin
                    w_state     = ST_SERVE;
                    w_cnt       = SERVE_LD;
                    w_ball_run  = 1'b0;
                    w_ball_load = 1'b1;
                    w_serve_dir = 1'b0;
                    w_score_a   = '0;
                    w_score_b   = '0;
                    w_game_over = 1'b0;
                    w_winner    = 1'b0;
                end
            end

            ST_SERVE: begin
                if (bus.frame_tick) begin
                    if (r_cnt == CNT_ONE) begin
                        w_state    = ST_PLAY;
                        w_ball_run = 1'b1;
                    end else begin
                        w_cnt = r_cnt - CNT_ONE;
                    end
                end
            end

            ST_PLAY: begin
                if (bus.miss_a && bus.miss_b) begin
                    w_state    = ST_POINT;
                    w_cnt      = POINT_LD;
                    w_ball_run = 1'b0;
                end else if (bus.miss_a) begin
                    w_ball_run  = 1'b0;
                    w_score_b   = w_inc_b;
                    w_serve_dir = 1'b0;
                    if (w_inc_b == WIN_VAL) begin
                        w_state     = ST_GAME_OVER;
                        w_game_over = 1'b1;
                        w_winner    = 1'b1;
                    end else begin
                        w_state = ST_POINT;
                        w_cnt   = POINT_LD;
                    end
                end else if (bus.miss_b) begin
                    w_ball_run  = 1'b0;
                    w_score_a   = w_inc_a;
                    w_serve_dir = 1'b1;
                    if (w_inc_a == WIN_VAL) begin
                        w_state     = ST_GAME_OVER;
                        w_game_over = 1'b1;
                        w_winner    = 1'b0;
                    end else begin
                        w_state = ST_POINT;
                        w_cnt   = POINT_LD;
                    end
                end
            end

            ST_POINT: begin
                if (bus.frame_tick) begin
                    if (r_cnt == CNT_ONE) begin
                        w_state     = ST_SERVE;
                        w_cnt       = SERVE_LD;
                        w_ball_load = 1'b1;
                    end else begin
                        w_cnt = r_cnt - CNT_ONE;
                    end
                end
            end

            default: w_state = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ball_run  <= 1'b0;
            r_ball_load <= 1'b0;
            r_serve_dir <= 1'b0;
            r_score_a   <= '0;
            r_score_b   <= '0;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
            r_start_q   <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_ball_run  <= w_ball_run;
            r_ball_load <= w_ball_load;
            r_serve_dir <= w_serve_dir;
            r_score_a   <= w_score_a;
            r_score_b   <= w_score_b;
            r_game_over <= w_game_over;
            r_winner    <= w_winner;
            r_start_q   <= bus.start_btn;
            r_armed     <= r_armed | ~bus.start_btn;
        end
    end

    assign bus.ball_run  = r_ball_run;
    assign bus.ball_load = r_ball_load;
    assign bus.serve_dir = r_serve_dir;
    assign bus.score_a   = r_score_a;
    assign bus.score_b   = r_score_b;
    assign bus.game_over = r_game_over;
    assign bus.winner    = r_winner;
    assign bus.state     = r_state;
endmodule

// File: doc/match_ctrl.md
# match_ctrl

Match sequencer for the ping-pong game: owns the game-level state machine that gates the ball/paddle datapath in the game logic. Runs on the 25 MHz pixel clock. Consumes debounced start input, per-frame tick and ball-miss pulses from the datapath. Drives ball enable/recenter, serve direction, both scores and game-over status to the datapath and score renderer.

## Interface
- SCORE_W, 4: width of each score counter
- WIN_SCORE, 7: points that end the match; 1..2^SCORE_W-1
- SERVE_FRAMES, 60: frames between ball recenter and launch; >=1
- POINT_FRAMES, 30: frames of freeze after a point; >=1
- pixel_clk  in  1  25 MHz pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; all registers cleared while low
- start_btn  in  1  debounced start level, synchronous to pixel_clk
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blanking)
- miss_a  in  1  one-cycle pulse: ball passed player A's edge
- miss_b  in  1  one-cycle pulse: ball passed player B's edge
- ball_run  out  1  ball motion enable
- ball_load  out  1  one-cycle pulse: recenter ball, load direction from serve_dir
- serve_dir  out  1  0 = launch toward B, 1 = launch toward A
- score_a  out  SCORE_W  player A points
- score_b  out  SCORE_W  player B points
- game_over  out  1  match finished
- winner  out  1  0 = A, 1 = B; valid while game_over=1
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4

## Operation
- Reset value, all outputs: 0 (state=IDLE). Internal frame counter 0, start_q 0.
- start_edge = start_btn & ~start_q; start_q registers start_btn every cycle.
- IDLE: on start_edge -> SERVE; scores cleared, serve_dir=0, cnt=SERVE_FRAMES, ball_load=1 for one cycle.
- SERVE: ball_run=0. On frame_tick: cnt==1 -> PLAY (ball_run=1); else cnt-1.
- PLAY: ball_run=1.
  - miss_a only: score_b+1, serve_dir=0 (A serves).
  - miss_b only: score_a+1, serve_dir=1 (B serves).
  - miss_a and miss_b same cycle: no score change, serve_dir unchanged, -> POINT.
  - incremented score == WIN_SCORE -> GAME_OVER, game_over=1, winner = scorer, ball_run=0.
  - otherwise -> POINT, cnt=POINT_FRAMES, ball_run=0.
- POINT: ball_run=0. On frame_tick: cnt==1 -> SERVE, cnt=SERVE_FRAMES, ball_load=1 for one cycle; else cnt-1.
- GAME_OVER: scores and winner held. On start_edge -> same actions as IDLE start (scores 0, game_over 0, winner 0, serve_dir 0, ball_load pulse, SERVE).
- start_edge ignored in SERVE, PLAY, POINT. miss_a/miss_b ignored outside PLAY. frame_tick ignored in IDLE, PLAY, GAME_OVER.
- Scores never exceed WIN_SCORE; no wrap.
- ball_load never asserted in the same cycle as ball_run.

## Timing
- All outputs registered; every response appears the cycle after the triggering input edge.
- miss at cycle n: score, state and ball_run=0 visible at n+1.
- start_edge at cycle n: ball_load=1 and state=SERVE at n+1, ball_load=0 at n+2.
- SERVE lasts exactly SERVE_FRAMES frame_ticks; ball_run rises the cycle after the last one.
- POINT lasts exactly POINT_FRAMES frame_ticks; ball_load pulses the cycle after the last one.
- Miss in the same cycle as frame_tick in PLAY: miss handled, tick ignored.
- Reset asserted mid-match: all outputs 0 asynchronously; after release, IDLE; start_btn held high through release yields no start_edge until it falls and rises again.

## Test plan
Bench parameters: WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=1.
- Reset, start_btn 0->1 -> ball_load one cycle, state=1; after 2 frame_ticks state=2, ball_run=1, serve_dir=0.
- In PLAY pulse miss_b -> next cycle score_a=1, state=3, ball_run=0, serve_dir=1; 1 frame_tick -> ball_load pulse, state=1.
- Drive A to 3 via three miss_b points -> game_over=1, winner=0, state=4, score_a=3; further miss_a/miss_b/frame_tick leave all outputs unchanged.
- In PLAY pulse miss_a and miss_b together -> scores unchanged, state=3, serve_dir unchanged.
- In GAME_OVER rising start_btn -> scores 0, game_over 0, ball_load pulse, state=1; start_btn held high -> no second ball_load.
- Assert reset during PLAY with score_b=2 -> all outputs 0 immediately; miss pulses in IDLE ignored.
